// File: rtl/xor_frame_accumulator.sv
// Frame-wise XOR accumulator: folds a valid/ready word stream into one XOR/parity/count result per frame.
// Optional expected-word compare is built only when XOR_FRAME_ACCUMULATOR_CHECK_EN is defined.
module xor_frame_accumulator #(
  parameter  int WIDTH     = 8,
  parameter  int MAX_BEATS = 16,
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
`ifdef XOR_FRAME_ACCUMULATOR_CHECK_EN
  input  logic [WIDTH-1:0] exp_word,
  output logic             out_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_trunc
);

  typedef enum logic {ACC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             accept;
  logic             at_limit;

  assign accept   = in_valid && in_ready;
  assign acc_nxt  = acc ^ in_data;
  assign cnt_nxt  = cnt + CNT_W'(1);
  assign at_limit = (cnt_nxt == CNT_W'(MAX_BEATS));

  // in_ready/out_valid are flops so out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACC;
      acc        <= '0;
      cnt        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_word   <= '0;
      out_parity <= 1'b0;
      out_beats  <= '0;
      out_trunc  <= 1'b0;
`ifdef XOR_FRAME_ACCUMULATOR_CHECK_EN
      out_err    <= 1'b0;
`endif
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            if (in_last || at_limit) begin
              out_word   <= acc_nxt;
              out_parity <= ^acc_nxt;
              out_beats  <= cnt_nxt;
              out_trunc  <= !in_last;
`ifdef XOR_FRAME_ACCUMULATOR_CHECK_EN
              out_err    <= (acc_nxt != exp_word);
`endif
              acc        <= '0;
              cnt        <= '0;
              in_ready   <= 1'b0;
              out_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              acc <= acc_nxt;
              cnt <= cnt_nxt;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_frame_accumulator.sv
// Directed bench for xor_frame_accumulator (WIDTH=8, MAX_BEATS=4): table of frames plus hand-written
// sequences for reset, backpressure and reset-mid-frame.
module tb_xor_frame_accumulator;
  localparam int WIDTH = 8;
  localparam int MAX_BEATS = 4;
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_word;
  logic             out_parity;
  logic [CNT_W-1:0] out_beats;
  logic             out_trunc;
`ifdef XOR_FRAME_ACCUMULATOR_CHECK_EN
  logic [WIDTH-1:0] exp_word;
  logic             out_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  xor_frame_accumulator #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
`ifdef XOR_FRAME_ACCUMULATOR_CHECK_EN
    .exp_word   (exp_word),
    .out_err    (out_err),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .out_parity (out_parity),
    .out_beats  (out_beats),
    .out_trunc  (out_trunc)
  );

  typedef struct {
    logic [7:0] d [4];
    int         n;
    logic       last;
    logic [7:0] e_word;
    logic       e_par;
    int         e_beats;
    logic       e_trunc;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one beat at the falling edge, let it be taken at the next rising edge.
  task automatic beat(input logic [7:0] d, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
`ifdef XOR_FRAME_ACCUMULATOR_CHECK_EN
    exp_word = '0;
`endif
    vecs[0] = '{d: '{8'h0F, 8'hF0, 8'hFF, 8'h00}, n: 3, last: 1'b1, e_word: 8'h00, e_par: 1'b0, e_beats: 3, e_trunc: 1'b0};
    vecs[1] = '{d: '{8'h07, 8'h00, 8'h00, 8'h00}, n: 1, last: 1'b1, e_word: 8'h07, e_par: 1'b1, e_beats: 1, e_trunc: 1'b0};
    vecs[2] = '{d: '{8'h01, 8'h02, 8'h04, 8'h08}, n: 4, last: 1'b0, e_word: 8'h0F, e_par: 1'b0, e_beats: 4, e_trunc: 1'b1};
    vecs[3] = '{d: '{8'h10, 8'h00, 8'h00, 8'h00}, n: 1, last: 1'b1, e_word: 8'h10, e_par: 1'b1, e_beats: 1, e_trunc: 1'b0};
    vecs[4] = '{d: '{8'h33, 8'h55, 8'h0F, 8'hFF}, n: 4, last: 1'b1, e_word: 8'h96, e_par: 1'b0, e_beats: 4, e_trunc: 1'b0};
    vecs[5] = '{d: '{8'hA5, 8'h5A, 8'h00, 8'h00}, n: 2, last: 1'b1, e_word: 8'hFF, e_par: 1'b0, e_beats: 2, e_trunc: 1'b0};

    // Reset held two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_word", 32'(out_word), 32'h00);
    chk("rst_out_beats", 32'(out_beats), 32'd0);
    chk("rst_out_trunc", 32'(out_trunc), 32'd0);
    chk("rst_out_parity", 32'(out_parity), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Backpressure: result must hold while a competing beat is offered
    beat(8'hA5, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_word", 32'(out_word), 32'hA5);
      chk("bp_out_beats", 32'(out_beats), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    release_result();

    // Table of frames, each released immediately
    for (int v = 0; v < 6; v++) begin
      for (int b = 0; b < vecs[v].n; b++)
        beat(vecs[v].d[b], (b == vecs[v].n - 1) ? vecs[v].last : 1'b0);
      chk("vec_out_valid", 32'(out_valid), 32'd1);
      chk("vec_in_ready", 32'(in_ready), 32'd0);
      chk("vec_out_word", 32'(out_word), 32'(vecs[v].e_word));
      chk("vec_out_parity", 32'(out_parity), 32'(vecs[v].e_par));
      chk("vec_out_beats", 32'(out_beats), 32'(vecs[v].e_beats));
      chk("vec_out_trunc", 32'(out_trunc), 32'(vecs[v].e_trunc));
      release_result();
    end

    // Reset mid-frame discards partial accumulation
    beat(8'h3C, 1'b0);
    beat(8'hC3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
`ifdef XOR_FRAME_ACCUMULATOR_CHECK_EN
    exp_word = 8'h55;
`endif
    beat(8'h55, 1'b1);
    chk("midrst_out_valid2", 32'(out_valid), 32'd1);
    chk("midrst_out_word", 32'(out_word), 32'h55);
    chk("midrst_out_beats", 32'(out_beats), 32'd1);
`ifdef XOR_FRAME_ACCUMULATOR_CHECK_EN
    chk("midrst_out_err", 32'(out_err), 32'd0);
`endif

    // Reset while a result is pending drops it
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("pendrst_out_valid", 32'(out_valid), 32'd0);
    chk("pendrst_in_ready", 32'(in_ready), 32'd1);
    chk("pendrst_out_word", 32'(out_word), 32'h00);

`ifdef XOR_FRAME_ACCUMULATOR_CHECK_EN
    exp_word = 8'h54;
    beat(8'h55, 1'b1);
    chk("err_out_err", 32'(out_err), 32'd1);
    release_result();
`endif

    // out_ready with no result pending is harmless
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle_ready_in_ready", 32'(in_ready), 32'd1);
    chk("idle_ready_out_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xor_frame_accumulator.md
Name: xor_frame_accumulator

Overview:
- Parametrised, clocked successor to the team's 2-input XOR primitive.
- Accepts a stream of WIDTH-bit words over a valid/ready handshake and accumulates a running bitwise XOR across a frame, where a frame ends on in_last.
- Presents the frame result (XOR word, reduction parity, beat count) on a valid/ready output.
- Used as a lightweight frame checksum/parity stage between stream producers and consumers.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- MAX_BEATS, 16, maximum beats per frame before forced truncation (>=1).
- CNT_W, $clog2(MAX_BEATS+1), width of beat counter/out_beats (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  input word.
- in_last  input  1  word is final beat of frame.
- out_valid  output  1  frame result available.
- out_ready  input  1  consumer accepts result.
- out_word  output  WIDTH  XOR of all accepted beats in frame.
- out_parity  output  1  reduction XOR of out_word (1 = odd number of set bits).
- out_beats  output  CNT_W  number of beats in frame (1..MAX_BEATS).
- out_trunc  output  1  frame closed by MAX_BEATS limit, not in_last.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: state=ACC, acc=0, cnt=0, in_ready=1, out_valid=0, out_word=0, out_parity=0, out_beats=0, out_trunc=0. Reset mid-frame discards partial accumulation; a pending result is dropped.
- Beat accepted when in_valid && in_ready at a rising edge.
- State ACC:
  - in_ready=1, out_valid=0.
  - On accept: acc <= acc ^ in_data; cnt <= cnt+1.
  - If in_last, or cnt+1 == MAX_BEATS: latch out_word=acc^in_data, out_beats=cnt+1, out_trunc=!in_last, out_parity=^(acc^in_data). Then clear acc/cnt and go to DONE.
  - in_last and limit on the same beat: out_trunc=0.
- State DONE:
  - in_ready=0, out_valid=1; outputs held stable.
  - On out_ready: go to ACC; in_ready=1 the next cycle.
  - No combinational path from out_ready to in_ready. Minimum one bubble cycle between frames.
- Latency: result visible the cycle after the last beat is accepted (1 clk).
- in_last with in_valid=0 is ignored. in_data/in_last are don't-care when in_valid=0.
- Empty frames are impossible: every frame contains >=1 beat.
- cnt never exceeds MAX_BEATS; no wrap-around.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: XOR_FRAME_ACCUMULATOR_CHECK_EN.
- When defined:
  - Adds input port exp_word (WIDTH) and output port out_err (1).
  - exp_word is sampled on the frame-closing beat.
  - out_err = (final XOR != exp_word), latched with the other results; reset value 0.
- When undefined: neither port exists and no compare logic is built. All other behaviour is identical.

Test Plan (WIDTH=8, MAX_BEATS=4):
- Reset: hold rst 2 cycles -> in_ready=1, out_valid=0, out_word=0x00, out_beats=0, out_trunc=0.
- Frame 0x0F, 0xF0, 0xFF(last), out_ready=1 -> out_valid=1 one cycle after last; out_word=0x00, out_parity=0, out_beats=3, out_trunc=0; in_ready=1 the following cycle.
- Single beat 0x07 with last -> out_word=0x07, out_parity=1, out_beats=1.
- Backpressure: after frame 0xA5(last), hold out_ready=0 for 5 cycles -> out_valid=1, in_ready=0, out_word=0xA5 stable throughout; new in_valid is ignored. Raise out_ready -> next cycle in_ready=1.
- Truncation: 0x01, 0x02, 0x04, 0x08 with no last -> out_word=0x0F, out_beats=4, out_trunc=1, out_parity=0. Next beat 0x10(last) forms a new frame: out_word=0x10, out_beats=1.
- Reset mid-frame: accept 0x3C, 0xC3, assert rst 1 cycle, then 0x55(last) -> out_word=0x55, out_beats=1. With CHECK_EN and exp_word=0x55 -> out_err=0; with exp_word=0x54 -> out_err=1.
